// File: rtl/entropy_src_ht_window_pkg.sv
// Shared types and constants for the health-test window sequencer.
package entropy_src_ht_window_pkg;

  localparam int unsigned StateWidth = 6;

  // Sparse codes so a single upset cannot land on another legal state.
  typedef enum logic [StateWidth-1:0] {
    HtIdle   = 6'b101100,
    HtStart  = 6'b010011,
    HtCount  = 6'b110101,
    HtReport = 6'b001110,
    HtError  = 6'b111011
  } ht_win_state_e;

  localparam logic [15:0] AlertCntMax = '1;
  localparam logic [31:0] FailTotMax  = '1;

endpackage

// File: rtl/entropy_src_sat_cntr.sv
// Saturating up-counter with synchronous clear; clear and increment together yields 1.
module entropy_src_sat_cntr #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] CntMax = '1;

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end
    if (inc_i) begin
      if (clr_i) begin
        cnt_d = Width'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/entropy_src_ht_window_ctrl.sv
// Health-test window sequencer: counts samples into windows, reports done/fail and tracks alerts.
module entropy_src_ht_window_ctrl
  import entropy_src_ht_window_pkg::*;
#(
  parameter int unsigned WinCntWidth   = 16,
  parameter int unsigned AlertCntWidth = 16,
  parameter int unsigned NumTests      = 5,
  parameter int unsigned FailTotWidth  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     bypass_mode_i,
  input  logic                     ent_valid_i,
  input  logic [WinCntWidth-1:0]   win_size_i,
  input  logic [WinCntWidth-1:0]   bypass_win_size_i,
  input  logic [NumTests-1:0]      test_fail_i,
  input  logic [AlertCntWidth-1:0] alert_threshold_i,
  input  logic                     rst_alert_cntr_i,
  output logic                     ht_done_pulse_o,
  output logic                     ht_fail_pulse_o,
  output logic                     alert_thresh_fail_o,
  output logic                     win_clr_o,
  output logic [WinCntWidth-1:0]   win_cnt_o,
  output logic [AlertCntWidth-1:0] alert_cnt_o,
  output logic [FailTotWidth-1:0]  fail_tot_o,
  output logic                     err_o
);

  ht_win_state_e state_q, state_d;

  logic [WinCntWidth-1:0]   win_cnt_q, win_cnt_d;
  logic [WinCntWidth-1:0]   len_q, len_d;
  logic [WinCntWidth-1:0]   len_sel, len_new, cur_len, cnt_base;
  logic [NumTests-1:0]      sticky_q, sticky_d;
  logic                     win_start, win_last, report, fail, alert_inc;
  logic [AlertCntWidth:0]   alert_nxt;

  assign len_sel = bypass_mode_i ? bypass_win_size_i : win_size_i;
  assign len_new = (len_sel == '0) ? WinCntWidth'(1) : len_sel;

  // Start and Report open a fresh window, so their sample is checked against the newly latched length.
  assign win_start = (state_q == HtStart) || (state_q == HtReport);
  assign cur_len   = win_start ? len_new : len_q;
  assign cnt_base  = win_start ? '0 : win_cnt_q;
  assign win_last  = ent_valid_i && (cnt_base == cur_len - WinCntWidth'(1));

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    len_d     = len_q;
    sticky_d  = sticky_q;
    unique case (state_q)
      HtIdle: begin
        win_cnt_d = '0;
        sticky_d  = '0;
        if (enable_i) begin
          state_d = HtStart;
        end
      end
      HtStart, HtCount, HtReport: begin
        if (!enable_i) begin
          state_d   = HtIdle;
          win_cnt_d = '0;
          sticky_d  = '0;
        end else begin
          if (win_start) begin
            len_d = len_new;
          end
          sticky_d  = (win_start ? '0 : sticky_q) | test_fail_i;
          win_cnt_d = win_last ? '0 : cnt_base + WinCntWidth'(ent_valid_i);
          state_d   = win_last ? HtReport : HtCount;
        end
      end
      HtError: state_d = HtError;
      default: state_d = HtError;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= HtIdle;
      win_cnt_q <= '0;
      len_q     <= '0;
      sticky_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      len_q     <= len_d;
      sticky_q  <= sticky_d;
    end
  end

  assign report    = (state_q == HtReport) && enable_i;
  assign fail      = report && (|sticky_q);
  assign alert_inc = fail;
  assign alert_nxt = {1'b0, alert_cnt_o} + (AlertCntWidth + 1)'(1);

  assign ht_done_pulse_o     = report;
  assign ht_fail_pulse_o     = fail;
  assign alert_thresh_fail_o = fail && (alert_threshold_i != '0) &&
                               (alert_nxt >= {1'b0, alert_threshold_i});
  assign win_clr_o           = enable_i && win_start;
  assign win_cnt_o           = win_cnt_q;
  assign err_o               = (state_q == HtError);

  entropy_src_sat_cntr #(
    .Width(AlertCntWidth)
  ) u_alert_cntr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (rst_alert_cntr_i),
    .inc_i (alert_inc),
    .cnt_o (alert_cnt_o)
  );

  entropy_src_sat_cntr #(
    .Width(FailTotWidth)
  ) u_fail_tot_cntr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (fail),
    .cnt_o (fail_tot_o)
  );

endmodule

// File: tb/tb_entropy_src_ht_window_ctrl.sv
// Self-checking bench: window-level model checked every cycle plus directed literal pins.
module tb_entropy_src_ht_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        bypass_mode_i = 1'b0;
  logic        ent_valid_i = 1'b0;
  logic [15:0] win_size_i = 16'd4;
  logic [15:0] bypass_win_size_i = 16'd4;
  logic [4:0]  test_fail_i = '0;
  logic [15:0] alert_threshold_i = '0;
  logic        rst_alert_cntr_i = 1'b0;
  logic        ht_done_pulse_o, ht_fail_pulse_o, alert_thresh_fail_o, win_clr_o, err_o;
  logic [15:0] win_cnt_o, alert_cnt_o;
  logic [31:0] fail_tot_o;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int d0;

  always #5 clk = ~clk;

  entropy_src_ht_window_ctrl #(
    .WinCntWidth(16), .AlertCntWidth(16), .NumTests(5), .FailTotWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .bypass_mode_i(bypass_mode_i),
    .ent_valid_i(ent_valid_i), .win_size_i(win_size_i), .bypass_win_size_i(bypass_win_size_i),
    .test_fail_i(test_fail_i), .alert_threshold_i(alert_threshold_i),
    .rst_alert_cntr_i(rst_alert_cntr_i), .ht_done_pulse_o(ht_done_pulse_o),
    .ht_fail_pulse_o(ht_fail_pulse_o), .alert_thresh_fail_o(alert_thresh_fail_o),
    .win_clr_o(win_clr_o), .win_cnt_o(win_cnt_o), .alert_cnt_o(alert_cnt_o),
    .fail_tot_o(fail_tot_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a window is open while enabled; it collects samples until its length is reached,
  // and the following cycle reports it while the next window already collects.
  bit      m_live = 0;
  bit      m_on, m_first, m_rep;
  int      m_cnt, m_len;
  bit      m_sticky;
  longint  m_alert, m_tot;

  always @(posedge clk) begin
    bit inc;
    int sel;
    if (rst_i) begin
      m_live = 1; m_on = 0; m_first = 0; m_rep = 0;
      m_cnt = 0; m_len = 0; m_sticky = 0; m_alert = 0; m_tot = 0;
    end else if (m_live) begin
      inc = m_on && enable_i && m_rep && m_sticky;
      if (inc) begin
        m_alert = rst_alert_cntr_i ? 1 : (m_alert == 65535 ? m_alert : m_alert + 1);
        m_tot   = (m_tot == 64'hFFFF_FFFF) ? m_tot : m_tot + 1;
      end else if (rst_alert_cntr_i) begin
        m_alert = 0;
      end
      if (!m_on) begin
        m_first = 0; m_rep = 0; m_cnt = 0; m_sticky = 0;
        if (enable_i) begin m_on = 1; m_first = 1; end
      end else if (!enable_i) begin
        m_on = 0; m_first = 0; m_rep = 0; m_cnt = 0; m_sticky = 0;
      end else begin
        if (m_first || m_rep) begin
          sel = int'(bypass_mode_i ? bypass_win_size_i : win_size_i);
          m_len = (sel == 0) ? 1 : sel;
          m_cnt = 0;
          m_sticky = 0;
        end
        m_sticky = m_sticky | (|test_fail_i);
        m_first = 0;
        m_rep = 0;
        if (ent_valid_i) begin
          m_cnt++;
          if (m_cnt == m_len) begin m_rep = 1; m_cnt = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit e_done, e_fail;
    if (m_live && !rst_i) begin
      e_done = m_rep && enable_i;
      e_fail = e_done && m_sticky;
      chk("done", 32'(ht_done_pulse_o), 32'(e_done));
      chk("fail", 32'(ht_fail_pulse_o), 32'(e_fail));
      chk("thresh", 32'(alert_thresh_fail_o),
          32'(e_fail && alert_threshold_i != 0 && (m_alert + 1 >= longint'(alert_threshold_i))));
      chk("win_clr", 32'(win_clr_o), 32'(enable_i && (m_first || m_rep)));
      chk("win_cnt", 32'(win_cnt_o), 32'(m_cnt));
      chk("alert_cnt", 32'(alert_cnt_o), 32'(m_alert));
      chk("fail_tot", fail_tot_o, 32'(m_tot));
      chk("err", 32'(err_o), 32'd0);
      if (ht_done_pulse_o === 1'b1) done_seen++;
    end
  end

  task automatic step(input logic v, input logic [4:0] f);
    ent_valid_i = v;
    test_fail_i = f;
    @(posedge clk);
    #1;
  endtask

  task automatic win4(input logic [4:0] f2);
    step(1'b1, 5'd0); step(1'b1, f2); step(1'b1, 5'd0); step(1'b1, 5'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_done", 32'(ht_done_pulse_o), 0);
    chk("rst_win_cnt", 32'(win_cnt_o), 0);
    chk("rst_alert", 32'(alert_cnt_o), 0);
    chk("rst_tot", fail_tot_o, 0);
    chk("rst_err", 32'(err_o), 0);

    // clean window of 4
    enable_i = 1'b1;
    step(1'b0, 5'd0);
    chk("t1_start_clr", 32'(win_clr_o), 1);
    win4(5'd0);
    chk("t1_done", 32'(ht_done_pulse_o), 1);
    chk("t1_fail", 32'(ht_fail_pulse_o), 0);
    chk("t1_clr", 32'(win_clr_o), 1);

    // failing window, then clean window
    win4(5'b00100);
    chk("t2_fail", 32'(ht_fail_pulse_o), 1);
    chk("t2_alert_pre", 32'(alert_cnt_o), 0);
    step(1'b0, 5'd0);
    chk("t2_alert", 32'(alert_cnt_o), 1);
    chk("t2_tot", fail_tot_o, 1);
    win4(5'd0);
    chk("t2_clean_done", 32'(ht_done_pulse_o), 1);
    chk("t2_clean_fail", 32'(ht_fail_pulse_o), 0);

    // threshold 2 then threshold 0
    alert_threshold_i = 16'd2;
    rst_alert_cntr_i = 1'b1; step(1'b0, 5'd0); rst_alert_cntr_i = 1'b0;
    win4(5'b00001);
    chk("t3_thr_first", 32'(alert_thresh_fail_o), 0);
    win4(5'b00001);
    chk("t3_thr_second", 32'(alert_thresh_fail_o), 1);
    alert_threshold_i = 16'd0;
    rst_alert_cntr_i = 1'b1; step(1'b0, 5'd0); rst_alert_cntr_i = 1'b0;
    chk("t3_clr_inc", 32'(alert_cnt_o), 1);
    win4(5'b10000);
    chk("t3_thr0_a", 32'(alert_thresh_fail_o), 0);
    win4(5'b10000);
    chk("t3_thr0_b", 32'(alert_thresh_fail_o), 0);

    // clear and increment in the same cycle with count 3
    step(1'b0, 5'd0);
    chk("t4_alert3", 32'(alert_cnt_o), 3);
    win4(5'b01000);
    chk("t4_fail", 32'(ht_fail_pulse_o), 1);
    rst_alert_cntr_i = 1'b1; step(1'b0, 5'd0); rst_alert_cntr_i = 1'b0;
    chk("t4_alert1", 32'(alert_cnt_o), 1);
    chk("t4_tot", fail_tot_o, 6);

    // disable mid-window
    step(1'b1, 5'd0); step(1'b1, 5'd0);
    chk("t5_cnt2", 32'(win_cnt_o), 2);
    enable_i = 1'b0;
    step(1'b1, 5'd0);
    chk("t5_idle_cnt", 32'(win_cnt_o), 0);
    step(1'b1, 5'd0); step(1'b1, 5'd0);
    chk("t5_alert_kept", 32'(alert_cnt_o), 1);
    enable_i = 1'b1;
    step(1'b0, 5'd0);
    chk("t5_restart_clr", 32'(win_clr_o), 1);
    step(1'b1, 5'd0); step(1'b1, 5'd0); step(1'b1, 5'd0);
    chk("t5_no_early_done", 32'(ht_done_pulse_o), 0);
    step(1'b1, 5'd0);
    chk("t5_done", 32'(ht_done_pulse_o), 1);

    // len=1 and len=0 continuous streams
    for (int k = 0; k < 2; k++) begin
      enable_i = 1'b0; step(1'b0, 5'd0);
      win_size_i = (k == 0) ? 16'd1 : 16'd0;
      enable_i = 1'b1; step(1'b0, 5'd0);
      d0 = done_seen;
      repeat (8) step(1'b1, 5'd0);
      step(1'b0, 5'd0);
      chk(k == 0 ? "t6_len1_dones" : "t6_len0_dones", 32'(done_seen - d0), 8);
    end

    // bypass window size
    enable_i = 1'b0; step(1'b0, 5'd0);
    win_size_i = 16'd4; bypass_win_size_i = 16'd2; bypass_mode_i = 1'b1;
    enable_i = 1'b1; step(1'b0, 5'd0);
    step(1'b1, 5'd0); step(1'b1, 5'd0);
    chk("t7_bypass_done", 32'(ht_done_pulse_o), 1);

    // reset mid-window
    step(1'b1, 5'b00010);
    rst_i = 1'b1; step(1'b0, 5'd0); rst_i = 1'b0;
    chk("t8_rst_cnt", 32'(win_cnt_o), 0);
    chk("t8_rst_alert", 32'(alert_cnt_o), 0);
    chk("t8_rst_tot", fail_tot_o, 0);
    chk("t8_rst_done", 32'(ht_done_pulse_o), 0);
    step(1'b0, 5'd0);
    step(1'b0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/entropy_src_ht_window_ctrl.md
Name: entropy_src_ht_window_ctrl

Overview:
Health-test window sequencer that sits directly upstream of the entropy_src main state machine.
- Counts tested raw-entropy samples into windows and aggregates per-test failure pulses from the health-test units.
- At each window end it produces the ht_done / ht_fail pulses the main SM consumes.
- Maintains the consecutive-failure alert counter and the alert-threshold decision, and honours the main SM's rst_alert_cntr request.

Parameters:
WinCntWidth, 16, width of window-size config and sample counter
AlertCntWidth, 16, width of alert threshold and alert counter
NumTests, 5, number of health-test fail-pulse inputs
FailTotWidth, 32, width of total-failed-window statistic

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
enable_i  in  1  module enable; low forces Idle
bypass_mode_i  in  1  selects bypass window size
ent_valid_i  in  1  one tested sample this cycle
win_size_i  in  WinCntWidth  normal-mode window length in samples
bypass_win_size_i  in  WinCntWidth  bypass/boot window length in samples
test_fail_i  in  NumTests  per-test fail pulses, any cycle
alert_threshold_i  in  AlertCntWidth  failing windows before alert; 0 disables alert
rst_alert_cntr_i  in  1  clear alert counter (from main SM)
ht_done_pulse_o  out  1  window complete, 1-cycle pulse
ht_fail_pulse_o  out  1  window failed; only valid with ht_done_pulse_o
alert_thresh_fail_o  out  1  threshold reached; only with ht_done_pulse_o
win_clr_o  out  1  pulse telling test units to clear window stats
win_cnt_o  out  WinCntWidth  samples in current window
alert_cnt_o  out  AlertCntWidth  current alert count
fail_tot_o  out  FailTotWidth  total failed windows, saturating
err_o  out  1  illegal FSM state

Behaviour:
- Reset: all outputs 0, FSM Idle, counters 0, sticky fail vector 0.
- FSM states: Idle, Start, Count, Report, Error. Encoded sparse, type from package.
- Idle:
  - enable_i=1 -> Start.
  - While in Idle: win_cnt = 0, sticky = 0.
- Start (1 cycle):
  - win_clr_o=1.
  - Latch window length: bypass_mode_i ? bypass_win_size_i : win_size_i. A latched value of 0 is treated as 1.
  - -> Count.
  - ent_valid_i during Start counts as a sample.
- Count:
  - Each ent_valid_i increments win_cnt.
  - test_fail_i ORs into sticky.
  - When ent_valid_i and win_cnt == len-1 -> Report.
  - Fail pulses in that same cycle are included in this window.
- Report (1 cycle):
  - ht_done_pulse_o=1.
  - ht_fail_pulse_o = |sticky.
  - alert_thresh_fail_o = fail && thr!=0 && (alert_cnt+1 >= thr), computed from the pre-update count.
  - win_clr_o=1; sticky cleared; window length re-latched; -> Count.
  - ent_valid_i and test_fail_i in Report belong to the next window (win_cnt=1 if ent_valid_i). No sample is dropped.
- Latency: last sample at cycle N -> ht_done_pulse_o at N+1. Back-to-back windows have no gap cycle.
- Alert counter:
  - Increments on a failing Report, saturating at all-ones.
  - rst_alert_cntr_i clears it. Clear and increment in the same cycle gives 1.
  - Persists across disable; cleared only by rst_i or rst_alert_cntr_i.
- fail_tot_o increments on every failing Report, saturating. Clears only on rst_i.
- enable_i low in any non-Error state -> Idle next cycle.
  - No done pulse is emitted for a partial window.
  - Report suppressed if enable_i is low in that cycle.
- Config changes mid-window have no effect until the next Start/Report latch.
- Undefined state -> Error: err_o=1, all pulses 0. Only rst_i exits Error.
- rst_i mid-window: everything to reset values next cycle; partial window discarded.

Decomposition:
- Package entropy_src_ht_window_pkg: sparse state enum and state width, plus the saturating-counter max constants.
- One natural sub-module: entropy_src_sat_cntr (parameterised width; inc/clr inputs; clr+inc gives 1). Used for the alert and fail-total counters.

Test Plan:
- len=4, 4 clean samples with ent_valid_i every cycle -> ht_done_pulse_o one cycle after 4th sample; ht_fail=0; win_clr_o pulses at Start and Report.
- len=4, test_fail_i[2] pulse on sample 2 -> ht_fail=1, alert_cnt_o 0->1, fail_tot_o=1; next clean window -> ht_fail=0.
- thr=2, two consecutive failing windows -> alert_thresh_fail_o=1 with 2nd ht_done only; thr=0 with the same stimulus -> never asserted.
- rst_alert_cntr_i asserted in the same cycle as a failing Report, with alert_cnt=3 -> alert_cnt_o=1.
- enable_i dropped after 2 of 4 samples -> no ht_done_pulse_o; re-enable -> Start, window counts from 0; alert_cnt retained.
- Continuous ent_valid_i across windows with len=1 -> ht_done every cycle after the first window, no lost samples; win_size_i=0 behaves identically.
